// File: rtl/mem_clear_pkg.sv
// Shared types and helpers for the post-boot memory clear arbiter (mem_clear_arb).
package mem_clear_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOST,
        DONE
    } state_t;

    localparam int HOST_MAX_DEF = 4;

    // Per-word test pattern: the word address, zero-extended into a 32-bit lane.
    function automatic logic [31:0] pattern_word(input logic [31:0] addr);
        return addr;
    endfunction

endpackage

// File: rtl/mem_clear_progress.sv
// Clear progress as upper 8 bits of words_written*256/length, tracked by a
// threshold accumulator that catches up one step per clock instead of dividing.
module mem_clear_progress #(
    parameter int AW = 29
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_length,
    input  logic          i_accept,
    output logic [7:0]    o_progress
);

    localparam int NW = AW + 8;

    logic [NW-1:0] r_num;
    logic [NW-1:0] r_thr;
    logic [AW-1:0] r_len;
    logic [7:0]    r_q;

    // r_num = count*256 and r_thr = (r_q+1)*length; r_q steps up while r_num has
    // reached the next threshold, so it settles on floor(count*256/length).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
            r_thr <= '0;
            r_len <= '0;
            r_q   <= '0;
        end else if (i_load) begin
            r_num <= '0;
            r_thr <= NW'(i_length);
            r_len <= i_length;
            r_q   <= '0;
        end else begin
            if (i_accept) begin
                r_num <= r_num + NW'(256);
            end
            if ((r_q != 8'hFF) && (r_len != '0) && (r_num >= r_thr)) begin
                r_q   <= r_q + 8'd1;
                r_thr <= r_thr + NW'(r_len);
            end
        end
    end

    assign o_progress = r_q;

endmodule

// File: rtl/mem_clear_arb.sv
// Post-boot RAM clear sequencer sharing one Avalon-style write port with a host.
// Optional: define MEMCLR_PATTERN_EN to write each word's address as its clear data.
module mem_clear_arb
    import mem_clear_pkg::*;
#(
    parameter int AW       = 29,
    parameter int DW       = 64,
    parameter int HOST_MAX = HOST_MAX_DEF
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   length,
    input  logic            host_req,
    input  logic [AW-1:0]   host_addr,
    input  logic [DW-1:0]   host_din,
    input  logic [DW/8-1:0] host_be,
    output logic            host_ack,
    input  logic            mem_busy,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    output logic [DW/8-1:0] mem_be,
    output logic            busy,
    output logic            done,
    output logic [7:0]      progress
);

    localparam int SW = (HOST_MAX < 1) ? 1 : $clog2(HOST_MAX + 1);

    state_t          r_state;
    logic            r_from_run;
    logic            r_abort_pend;
    logic            r_done;
    logic [AW-1:0]   r_cur;
    logic [AW-1:0]   r_remaining;
    logic [SW-1:0]   r_streak;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_din;
    logic [DW/8-1:0] r_mem_be;

    logic            w_accept;
    logic            w_free;
    logic            w_last;
    logic            w_host_win;
    logic            w_stop;
    logic [AW-1:0]   w_next_cur;
    logic [DW-1:0]   w_clear_din;
    logic [7:0]      w_progress;

    assign w_accept   = r_mem_we && !mem_busy;
    // The port is free when nothing is registered or the current command leaves this edge.
    assign w_free     = !r_mem_we || w_accept;
    assign w_last     = w_accept && (r_remaining == AW'(1));
    assign w_next_cur = w_accept ? (r_cur + AW'(1)) : r_cur;
    assign w_host_win = host_req && (r_streak != SW'(HOST_MAX));
    assign w_stop     = abort || r_abort_pend;

`ifdef MEMCLR_PATTERN_EN
    assign w_clear_din = {(DW/32){pattern_word(32'(w_next_cur))}};
`else
    assign w_clear_din = '0;
`endif

    // NOTE: nonblocking assignments throughout, so every branch reads pre-edge state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: command registers reset too, so an abandoned write never reappears.
            r_state      <= IDLE;
            r_from_run   <= 1'b0;
            r_abort_pend <= 1'b0;
            r_done       <= 1'b0;
            r_cur        <= '0;
            r_remaining  <= '0;
            r_streak     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_be     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur       <= base_addr;
                        r_remaining <= length;
                        r_streak    <= '0;
                        r_done      <= (length == '0);
                        r_state     <= (length == '0) ? DONE : RUN;
                    end else if (host_req) begin
                        r_state    <= HOST;
                        r_from_run <= 1'b0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= host_addr;
                        r_mem_din  <= host_din;
                        r_mem_be   <= host_be;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_cur       <= r_cur + AW'(1);
                        r_remaining <= r_remaining - AW'(1);
                    end
                    if (w_last) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_abort_pend <= 1'b0;
                    end else if (w_free) begin
                        if (w_stop) begin
                            r_state      <= IDLE;
                            r_mem_we     <= 1'b0;
                            r_abort_pend <= 1'b0;
                        end else if (w_host_win) begin
                            r_state    <= HOST;
                            r_from_run <= 1'b1;
                            r_streak   <= r_streak + SW'(1);
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= host_addr;
                            r_mem_din  <= host_din;
                            r_mem_be   <= host_be;
                        end else begin
                            r_streak   <= '0;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_next_cur;
                            r_mem_din  <= w_clear_din;
                            r_mem_be   <= '1;
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                HOST: begin
                    if (abort && r_from_run) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_accept) begin
                        r_mem_we <= 1'b0;
                        r_state  <= r_from_run ? RUN : IDLE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_clear_progress #(
        .AW(AW)
    ) u_progress (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .i_load     ((r_state == IDLE) && start),
        .i_length   (length),
        .i_accept   ((r_state == RUN) && w_accept),
        .o_progress (w_progress)
    );

    assign host_ack = (r_state == HOST) && w_accept;
    assign busy     = (r_state == RUN) || ((r_state == HOST) && r_from_run);
    assign done     = r_done;
    assign progress = r_done ? 8'hFF : w_progress;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_be   = r_mem_be;

endmodule

// File: tb/tb_mem_clear_arb.sv
// Directed bench for mem_clear_arb: scoreboard of expected memory writes popped on accept.
module tb_mem_clear_arb;

    localparam int AW = 29;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] length = '0;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_din = '0;
    logic [BW-1:0] host_be = '0;
    logic          host_ack;
    logic          mem_busy = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [BW-1:0] mem_be;
    logic          busy;
    logic          done;
    logic [7:0]    progress;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [BW-1:0] be;
        logic          host;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  ack_cnt = 0;
    bit  mon_en = 1'b1;

    mem_clear_arb #(.AW(AW), .DW(DW), .HOST_MAX(4)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_be   (host_be),
        .host_ack  (host_ack),
        .mem_busy  (mem_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_be    (mem_be),
        .busy      (busy),
        .done      (done),
        .progress  (progress)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_clear_din(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
`ifdef MEMCLR_PATTERN_EN
        return {w, w};
`else
        return (w == w) ? '0 : '1;
`endif
    endfunction

    function automatic logic [AW-1:0] h_addr(input int i);
        return AW'(32'h0010_0000 + i);
    endfunction

    function automatic logic [DW-1:0] h_din(input int i);
        return {32'hCAFE_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)};
    endfunction

    function automatic logic [BW-1:0] h_be(input int i);
        return BW'(i * 37 + 1);
    endfunction

    task automatic push_clear(input logic [AW-1:0] a);
        wr_t e;
        e.addr = a;
        e.din  = exp_clear_din(a);
        e.be   = '1;
        e.host = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_host(input int i);
        wr_t e;
        e.addr = h_addr(i);
        e.din  = h_din(i);
        e.be   = h_be(i);
        e.host = 1'b1;
        sb.push_back(e);
    endtask

    task automatic drive_host(input int i);
        host_addr = h_addr(i);
        host_din  = h_din(i);
        host_be   = h_be(i);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(posedge clk_sys); #1;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(posedge clk_sys); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Scoreboard consumer: every accepted memory command must match the next expected write.
    always @(negedge clk_sys) begin
        if (mon_en && reset_n === 1'b1) begin
            if (host_ack === 1'b1) ack_cnt++;
            if (mem_we === 1'b1 && mem_busy === 1'b0) begin
                check("write_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_din", mem_din, e.din);
                    check("wr_be", 64'(mem_be), 64'(e.be));
                    check("wr_host_ack", 64'(host_ack), 64'(e.host));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wb;
        int n;
        int acc;
        int hidx;
        int ack0;
        logic ack;

        // Reset state
        repeat (2) @(negedge clk_sys);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_din", mem_din, 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_progress", 64'(progress), 64'd0);
        check("rst_host_ack", 64'(host_ack), 64'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;

        // Basic clear: base 100, length 4, four back-to-back writes
        for (int k = 0; k < 4; k++) push_clear(AW'(100 + k));
        do_start(AW'(100), AW'(4));
        @(negedge clk_sys);
        check("t1_busy_run", 64'(busy), 64'd1);
        check("t1_done_cleared", 64'(done), 64'd0);
        check("t1_progress_start", 64'(progress), 64'd0);
        check("t1_no_cmd_yet", 64'(mem_we), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            check("t1_we_consecutive", 64'(mem_we), 64'd1);
        end
        @(negedge clk_sys);
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_off", 64'(busy), 64'd0);
        check("t1_we_off", 64'(mem_we), 64'd0);
        check("t1_progress_end", 64'(progress), 64'hFF);
        @(negedge clk_sys);
        check("t1_done_sticky", 64'(done), 64'd1);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Back-pressure on the second command
        for (int k = 0; k < 4; k++) push_clear(AW'(100 + k));
        do_start(AW'(100), AW'(4));
        n = 0;
        while (!(mem_we === 1'b1 && mem_addr === AW'(101)) && n < 20) begin
            @(posedge clk_sys); #1;
            n++;
        end
        check("t2_reach_101", 64'(mem_addr), 64'd101);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            check("t2_hold_we", 64'(mem_we), 64'd1);
            check("t2_hold_addr", 64'(mem_addr), 64'd101);
            check("t2_hold_din", mem_din, exp_clear_din(AW'(101)));
            check("t2_hold_be", 64'(mem_be), 64'hFF);
            @(posedge clk_sys); #1;
        end
        mem_busy = 1'b0;
        wait_done("t2_done", 20);
        @(negedge clk_sys);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Host write from IDLE: request at t, command at t+1, busy stays low
        push_host(100);
        @(posedge clk_sys); #1;
        drive_host(100);
        host_req = 1'b1;
        @(negedge clk_sys);
        check("t3_idle_no_we_yet", 64'(mem_we), 64'd0);
        @(negedge clk_sys);
        check("t3_idle_we", 64'(mem_we), 64'd1);
        check("t3_idle_ack", 64'(host_ack), 64'd1);
        check("t3_idle_busy", 64'(busy), 64'd0);
        @(posedge clk_sys); #1;
        host_req = 1'b0;
        @(negedge clk_sys);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Host held through a length-10 clear: 4 host writes, then 1 clear, repeated
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) push_host(4 * k + j);
            push_clear(AW'(200 + k));
        end
        ack0 = ack_cnt;
        do_start(AW'(200), AW'(10));
        hidx = 0;
        drive_host(0);
        host_req = 1'b1;
        n = 0;
        while (!(done === 1'b1 && hidx == 40) && n < 400) begin
            @(negedge clk_sys);
            ack = host_ack;
            @(posedge clk_sys); #1;
            n++;
            if (ack === 1'b1) begin
                hidx++;
                if (hidx < 40) drive_host(hidx);
                else host_req = 1'b0;
            end
        end
        host_req = 1'b0;
        check("t4_host_writes", 64'(hidx), 64'd40);
        check("t4_done", 64'(done), 64'd1);
        @(negedge clk_sys);
        check("t4_ack_count", 64'(ack_cnt - ack0), 64'd40);
        check("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Abort together with the third accept of a length-8 clear
        for (int k = 0; k < 3; k++) push_clear(AW'(300 + k));
        do_start(AW'(300), AW'(8));
        acc = 0;
        n = 0;
        while (acc < 3 && n < 30) begin
            @(negedge clk_sys);
            if (mem_we === 1'b1 && mem_busy === 1'b0) begin
                acc++;
                if (acc == 3) abort = 1'b1;
            end
            @(posedge clk_sys); #1;
            abort = 1'b0;
            n++;
        end
        @(negedge clk_sys);
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_done", 64'(done), 64'd0);
        check("t5_abort_we", 64'(mem_we), 64'd0);
        repeat (120) @(negedge clk_sys);
        check("t5_abort_progress", 64'(progress), 64'd96);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Zero-length start: straight to DONE, no writes
        do_start(AW'(500), AW'(0));
        check("t6_done", 64'(done), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_we", 64'(mem_we), 64'd0);
        check("t6_progress", 64'(progress), 64'hFF);
        repeat (3) @(negedge clk_sys);

        // Restart after abort begins again at base
        for (int k = 0; k < 8; k++) push_clear(AW'(300 + k));
        do_start(AW'(300), AW'(8));
        wait_done("t7_done", 40);
        @(negedge clk_sys);
        check("t7_sb_empty", 64'(sb.size()), 64'd0);

        // Address wrap past all-ones
        wb = '1;
        wb = wb - AW'(1);
        for (int k = 0; k < 4; k++) push_clear(wb + AW'(k));
        do_start(wb, AW'(4));
        wait_done("t8_done", 40);
        @(negedge clk_sys);
        check("t8_sb_empty", 64'(sb.size()), 64'd0);

        // Base 5: clear data is the address pattern when enabled, zero otherwise
        for (int k = 0; k < 2; k++) push_clear(AW'(5 + k));
        do_start(AW'(5), AW'(2));
        wait_done("t9_done", 40);
        @(negedge clk_sys);
        check("t9_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a clear
        mon_en = 1'b0;
        do_start(AW'(600), AW'(50));
        repeat (5) @(negedge clk_sys);
        check("t10_running", 64'(mem_we), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t10_rst_we", 64'(mem_we), 64'd0);
        check("t10_rst_addr", 64'(mem_addr), 64'd0);
        check("t10_rst_busy", 64'(busy), 64'd0);
        check("t10_rst_done", 64'(done), 64'd0);
        check("t10_rst_progress", 64'(progress), 64'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("t10_idle_after_reset", 64'(mem_we), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
